// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way round-robin picker with lock override
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  // A lock whose owner has dropped its request no longer blocks the other port.
  always_comb begin
    gnt = 2'b00;
    if (lock[0] && req[0]) begin
      gnt = 2'b01;
    end else if (lock[1] && req[1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = (last == PORT1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between two requesters with
// round-robin/lock arbitration, registered issue stage and tagged read return
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              tag_q, tag_d;
  logic [1:0]        rvalid_q, rvalid_d;

  logic [1:0] gnt;
  logic       acc0, acc1;

  mem_arb_pick u_pick (
    .req  ({Req1, Req0}),
    .last (last_q),
    .lock ({state_q == LOCK1, state_q == LOCK0}),
    .gnt  (gnt)
  );

  assign Gnt0 = gnt[0];
  assign Gnt1 = gnt[1];
  assign acc0 = Req0 & gnt[0];
  assign acc1 = Req1 & gnt[1];

  // With no acceptance nobody is requesting, so any lock owner has released.
  always_comb begin
    state_d  = ARB;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    tag_d    = tag_q;
    rvalid_d = {rd_q & (tag_q == PORT1), rd_q & (tag_q == PORT0)};
    if (acc0) begin
      state_d = Lock0 ? LOCK0 : ARB;
      last_d  = PORT0;
      addr_d  = Addr0;
      wdata_d = WData0;
      rd_d    = ~We0;
      wr_d    = We0;
      tag_d   = PORT0;
    end else if (acc1) begin
      state_d = Lock1 ? LOCK1 : ARB;
      last_d  = PORT1;
      addr_d  = Addr1;
      wdata_d = WData1;
      rd_d    = ~We1;
      wr_d    = We1;
      tag_d   = PORT1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ARB;
      last_q   <= PORT1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      tag_q    <= PORT0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_q    <= tag_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign MemoryRead   = rd_q;
  assign MemoryWrite  = wr_q;
  assign RValid0      = rvalid_q[0];
  assign RValid1      = rvalid_q[1];
  assign RData0       = MemReadData;
  assign RData1       = MemReadData;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 0, Req1 = 0, We0 = 0, We1 = 0, Lock0 = 0, Lock1 = 0;
  logic [5:0]  Addr0 = 0, Addr1 = 0;
  logic [31:0] WData0 = 0, WData1 = 0;
  logic        Gnt0, Gnt1, RValid0, RValid1, MemoryRead, MemoryWrite;
  logic [31:0] RData0, RData1, MemWriteData, MemReadData;
  logic [5:0]  MemAddress;

  mem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1), .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
    .RData0(RData0), .RData1(RData1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  // 64x32 memory: write commits at negedge, read captured at posedge
  logic [31:0] mem [64];
  always @(negedge Clock) if (MemoryWrite) mem[MemAddress] <= MemWriteData;
  always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ownership, round-robin history, shadow memory, expected returns
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } ret_t;

  logic [31:0] ref_mem [64];
  ret_t        rq[$];
  int          cyc = 0;
  int          owner = -1;
  int          last_port = 1;
  logic        exp_rd = 0, exp_wr = 0;
  logic [5:0]  exp_addr = 0;
  logic [31:0] exp_wdata = 0;
  logic        pend_w = 0;
  logic [5:0]  pend_a = 0;
  logic [31:0] pend_d = 0;

  function automatic int expected_grant(input logic [1:0] r);
    if (owner >= 0) return owner;
    if (r == 2'b11) return (last_port == 0) ? 1 : 0;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  // Called just after a posedge; one call = one clock cycle.
  task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    int          g;
    logic        v0, v1;
    logic [31:0] vd;
    logic [5:0]  ga;
    if (pend_w) begin
      ref_mem[pend_a] = pend_d;
      pend_w = 0;
    end
    #1;
    Req0 = r[0]; Req1 = r[1]; We0 = w[0]; We1 = w[1]; Lock0 = l[0]; Lock1 = l[1];
    Addr0 = a0; Addr1 = a1; WData0 = d0; WData1 = d1;
    #1;
    if (owner >= 0 && !r[owner]) owner = -1;
    g = expected_grant(r);
    check("gnt0", Gnt0, g == 0);
    check("gnt1", Gnt1, g == 1);
    check("mem_read", MemoryRead, exp_rd);
    check("mem_write", MemoryWrite, exp_wr);
    check("mem_addr", MemAddress, exp_addr);
    check("mem_wdata", MemWriteData, exp_wdata);
    v0 = 0; v1 = 0; vd = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      v0 = (rq[0].port == 0);
      v1 = (rq[0].port == 1);
      vd = rq[0].data;
      void'(rq.pop_front());
    end
    check("rvalid0", RValid0, v0);
    check("rvalid1", RValid1, v1);
    if (v0) check("rdata0", RData0, vd);
    if (v1) check("rdata1", RData1, vd);
    if (g >= 0) begin
      last_port = g;
      owner = l[g] ? g : -1;
      ga = (g == 0) ? a0 : a1;
      exp_addr = ga;
      exp_wdata = (g == 0) ? d0 : d1;
      exp_rd = ~w[g];
      exp_wr = w[g];
      if (w[g]) begin
        pend_w = 1; pend_a = ga; pend_d = exp_wdata;
      end else begin
        rq.push_back('{due: cyc + 2, port: g, data: ref_mem[ga]});
      end
    end else begin
      exp_rd = 0;
      exp_wr = 0;
    end
    @(posedge Clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
  endtask

  // Asserts reset mid-cycle, before the negedge, so any issued write is dropped too.
  task automatic do_reset();
    #3;
    Reset = 1'b1;
    #1;
    check("rst_mem_read", MemoryRead, 1'b0);
    check("rst_mem_write", MemoryWrite, 1'b0);
    check("rst_rvalid", {RValid1, RValid0}, 2'b00);
    check("rst_mem_addr", MemAddress, 6'd0);
    owner = -1; last_port = 1; exp_rd = 0; exp_wr = 0; exp_addr = 0; exp_wdata = 0;
    pend_w = 0;
    rq.delete();
    Req0 = 0; Req1 = 0; Lock0 = 0; Lock1 = 0;
    @(posedge Clock); cyc++;
    @(posedge Clock); cyc++;
    #2;
    check("rst_rvalid_hold", {RValid1, RValid0}, 2'b00);
    Reset = 1'b0;
    @(posedge Clock); cyc++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    #3;
    check("reset_gnt", {Gnt1, Gnt0}, 2'b00);
    check("reset_rd_wr", {MemoryRead, MemoryWrite}, 2'b00);
    check("reset_addr", MemAddress, 6'd0);
    check("reset_wdata", MemWriteData, 32'd0);
    check("reset_rvalid", {RValid1, RValid0}, 2'b00);
    #10;
    Reset = 1'b0;
    @(posedge Clock);

    // single read of preloaded word
    step(2'b01, 2'b00, 2'b00, 6'd5, 6'd0, 32'd0, 32'd0);
    idle(3);

    // contention: both read every cycle
    for (int i = 0; i < 8; i++)
      step(2'b11, 2'b00, 2'b00, 6'(i), 6'(i + 20), 32'd0, 32'd0);
    idle(3);

    // port 1 write then read of the same address
    step(2'b10, 2'b10, 2'b00, 6'd0, 6'd9, 32'd0, 32'h1234_5678);
    step(2'b10, 2'b00, 2'b00, 6'd0, 6'd9, 32'd0, 32'd0);
    idle(3);
    check("raw_mem9", ref_mem[9], 32'h1234_5678);

    // port 0 lock sequence with port 1 waiting
    step(2'b11, 2'b00, 2'b01, 6'd1, 6'd2, 32'd0, 32'd0);
    step(2'b11, 2'b00, 2'b01, 6'd3, 6'd2, 32'd0, 32'd0);
    step(2'b11, 2'b00, 2'b00, 6'd4, 6'd2, 32'd0, 32'd0);
    step(2'b11, 2'b00, 2'b00, 6'd4, 6'd2, 32'd0, 32'd0);
    idle(3);

    // lock 1, then drop Req1 while Req0 waits
    step(2'b10, 2'b00, 2'b10, 6'd0, 6'd7, 32'd0, 32'd0);
    step(2'b11, 2'b00, 2'b10, 6'd6, 6'd7, 32'd0, 32'd0);
    step(2'b01, 2'b00, 2'b00, 6'd6, 6'd7, 32'd0, 32'd0);
    idle(3);

    // reset between accept and return
    step(2'b01, 2'b00, 2'b00, 6'd5, 6'd0, 32'd0, 32'd0);
    do_reset();
    step(2'b11, 2'b00, 2'b00, 6'd8, 6'd10, 32'd0, 32'd0);
    idle(3);

    // randomized traffic over a small address window to exercise read-after-write
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(2'($urandom), 2'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
             6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), $urandom, $urandom);
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
